// File: rtl/modadd_arbiter_if.sv
// Bundle of request, adder and response signals between requesters, the arbiter and the shared
// modular adder. The slave view is the arbiter; the master view is its environment.
interface modadd_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]       mod_p;
  logic                   add_start;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic [WIDTH-1:0]       add_p;
  logic [WIDTH-1:0]       add_result;
  logic                   add_done;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   busy;

  modport slave (
    input  req_valid, req_a, req_b, mod_p, add_result, add_done, rsp_ready,
    output req_ready, add_start, add_a, add_b, add_p, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mod_p, add_result, add_done, rsp_ready,
    input  req_ready, add_start, add_a, add_b, add_p, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/modadd_arbiter.sv
// Round-robin arbiter that shares one modular adder between N_REQ requesters, one transaction in
// flight, with a watchdog on the adder done pulse and a tagged valid/ready response.
module modadd_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input logic             i_clk,
  input logic             i_rst_n,
  modadd_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [TW-1:0]       timer_q;
  logic                add_start_q;
  logic [WIDTH-1:0]    add_a_q, add_b_q, add_p_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [WIDTH-1:0]    rsp_data_q;
  logic                rsp_err_q;

  logic [2*N_REQ-1:0]  dbl, shifted;
  logic [N_REQ-1:0]    rot;
  logic [ID_W:0]       sum;
  logic                gnt_any;
  logic [ID_W-1:0]     gnt_idx, ptr_next;
  logic [WIDTH-1:0]    sel_a, sel_b;

  // Rotate the request vector so bit 0 is the current priority holder; the lowest set bit of
  // the rotated vector is the grant, counted from ptr_q.
  always_comb begin
    dbl     = {bus.req_valid, bus.req_valid};
    shifted = dbl >> ptr_q;
    rot     = shifted[N_REQ-1:0];
    gnt_any = |rot;
    sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
    end
    if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
    gnt_idx  = sum[ID_W-1:0];
    ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle) bus.req_ready = N_REQ'(gnt_any) << gnt_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      timer_q     <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_p_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            add_a_q     <= sel_a;
            add_b_q     <= sel_b;
            add_p_q     <= bus.mod_p;
            rsp_id_q    <= gnt_idx;
            ptr_q       <= ptr_next;
            add_start_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A done pulse on the expiry cycle still counts as success.
          if (bus.add_done) begin
            rsp_data_q  <= bus.add_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (timer_q == TLast) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_p     = add_p_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_modadd_arbiter.sv
// Self-checking bench for modadd_arbiter: directed scenarios plus a randomized phase, scored
// against a transaction-level round-robin and modular-add model.
module tb_modadd_arbiter;

  localparam int unsigned NReq    = 4;
  localparam int unsigned Width   = 256;
  localparam int unsigned Timeout = 8;
  localparam int unsigned IdW     = 2;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  modadd_arbiter_if #(.N_REQ(NReq), .WIDTH(Width), .ID_W(IdW)) bus ();

  modadd_arbiter #(
    .N_REQ  (NReq),
    .WIDTH  (Width),
    .TIMEOUT(Timeout),
    .ID_W   (IdW)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: operands held by each requester, modulus, round-robin pointer.
  logic [Width-1:0] ma [NReq];
  logic [Width-1:0] mb [NReq];
  logic [Width-1:0] mp;
  int               mptr;

  task automatic check(input string tag, input logic [Width-1:0] got, input logic [Width-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NReq-1:0] v, input int p);
    for (int k = 0; k < NReq; k++) begin
      if (v[IdW'((p + k) % NReq)]) return (p + k) % NReq;
    end
    return -1;
  endfunction

  function automatic logic [Width-1:0] modadd(input logic [Width-1:0] a, input logic [Width-1:0] b,
                                              input logic [Width-1:0] p);
    logic [Width:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[Width-1:0];
  endfunction

  function automatic logic [Width-1:0] rand_w();
    logic [Width-1:0] r;
    for (int i = 0; i < Width / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic set_req(input int i, input logic [Width-1:0] a, input logic [Width-1:0] b);
    ma[i] = a;
    mb[i] = b;
    bus.req_a[i*Width +: Width] = a;
    bus.req_b[i*Width +: Width] = b;
  endtask

  task automatic set_p(input logic [Width-1:0] p);
    mp = p;
    bus.mod_p = p;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_add_start"}, Width'(bus.add_start), Width'(0));
    check({tag, "_add_a"}, bus.add_a, '0);
    check({tag, "_add_b"}, bus.add_b, '0);
    check({tag, "_add_p"}, bus.add_p, '0);
    check({tag, "_rsp_valid"}, Width'(bus.rsp_valid), Width'(0));
    check({tag, "_rsp_id"}, Width'(bus.rsp_id), Width'(0));
    check({tag, "_rsp_data"}, bus.rsp_data, '0);
    check({tag, "_rsp_err"}, Width'(bus.rsp_err), Width'(0));
    check({tag, "_busy"}, Width'(bus.busy), Width'(0));
  endtask

  task automatic do_reset();
    bus.add_done  = 1'b0;
    bus.rsp_ready = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mptr = 0;
    @(negedge i_clk);
  endtask

  // One full transaction, entered at a negedge with the requests already driven.
  // dly: adder done arrives dly cycles after the start cycle; never: adder stays silent.
  task automatic run_txn(input int dly, input bit never, input bit frc, input logic [Width-1:0] fval,
                         input int bp, input bit drop, input bit late);
    int g, k, cyc;
    logic [Width-1:0] exp_data;
    cyc = 0;
    #1;
    while (bus.req_ready == '0 && cyc < 20) begin
      @(negedge i_clk);
      #1;
      cyc++;
    end
    g = pick(bus.req_valid, mptr);
    if (g < 0) g = 0;
    check("grant", Width'(bus.req_ready), Width'(NReq'(1) << g));
    if (bus.req_ready == '0) return;
    mptr = (g + 1) % NReq;
    exp_data = never ? '0 : (frc ? fval : modadd(ma[g], mb[g], mp));

    @(negedge i_clk);
    check("add_start", Width'(bus.add_start), Width'(1));
    check("issue_ready", Width'(bus.req_ready), Width'(0));
    check("add_a", bus.add_a, ma[g]);
    check("add_b", bus.add_b, mb[g]);
    check("add_p", bus.add_p, mp);
    check("busy", Width'(bus.busy), Width'(1));
    if (drop) bus.req_valid[IdW'(g)] = 1'b0;

    k = never ? Timeout + 1 : dly + 1;
    for (int j = 1; j <= k; j++) begin
      @(negedge i_clk);
      if (j == 1) check("start_pulse", Width'(bus.add_start), Width'(0));
      if (!never && j == dly) begin
        bus.add_done   = 1'b1;
        bus.add_result = frc ? fval : modadd(bus.add_a, bus.add_b, bus.add_p);
      end
      if (j == k - 1) check("rsp_early", Width'(bus.rsp_valid), Width'(0));
    end
    bus.add_done = 1'b0;
    check("rsp_valid", Width'(bus.rsp_valid), Width'(1));
    check("rsp_id", Width'(bus.rsp_id), Width'(g));
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_err", Width'(bus.rsp_err), Width'(never));

    for (int j = 0; j < bp; j++) begin
      if (late && j == 0) begin
        bus.add_done   = 1'b1;
        bus.add_result = '1;
      end
      @(negedge i_clk);
      bus.add_done = 1'b0;
      check("hold_valid", Width'(bus.rsp_valid), Width'(1));
      check("hold_id", Width'(bus.rsp_id), Width'(g));
      check("hold_data", bus.rsp_data, exp_data);
      check("hold_err", Width'(bus.rsp_err), Width'(never));
      check("hold_ready", Width'(bus.req_ready), Width'(0));
    end
    bus.rsp_ready = 1'b1;
    check("resp_no_grant", Width'(bus.req_ready), Width'(0));
    @(negedge i_clk);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", Width'(bus.rsp_valid), Width'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [NReq-1:0] add;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.mod_p      = '0;
    bus.add_result = '0;
    bus.add_done   = 1'b0;
    bus.rsp_ready  = 1'b0;
    mptr = 0;
    repeat (3) @(negedge i_clk);
    check_quiet("reset");
    check("reset_req_ready", Width'(bus.req_ready), Width'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single request from requester 1: (50 + 60) mod 97 = 13.
    set_p(Width'(97));
    set_req(1, Width'(50), Width'(60));
    bus.req_valid = 4'b0010;
    run_txn(3, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0);

    // Round-robin with all four requesters held.
    do_reset();
    set_p(rand_w() | {1'b1, {(Width - 1){1'b0}}});
    for (int i = 0; i < NReq; i++) set_req(i, Width'(100 + i), rand_w() % mp);
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) run_txn($urandom_range(1, 4), 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    bus.req_valid = '0;

    // Backpressure with requester 2 pending.
    do_reset();
    set_req(0, rand_w() % mp, rand_w() % mp);
    set_req(2, rand_w() % mp, rand_w() % mp);
    bus.req_valid = 4'b0101;
    run_txn(2, 1'b0, 1'b0, '0, 5, 1'b1, 1'b0);
    #1;
    check("rr_after_resp", Width'(bus.req_ready), Width'(4'b0100));
    run_txn(1, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0);

    // Timeout, with a late done during the response and another stray one in idle.
    bus.req_valid = 4'b0010;
    run_txn(0, 1'b1, 1'b0, '0, 3, 1'b1, 1'b1);
    bus.add_done   = 1'b1;
    bus.add_result = '1;
    @(negedge i_clk);
    bus.add_done = 1'b0;
    @(negedge i_clk);
    check("stray_busy", Width'(bus.busy), Width'(0));
    check("stray_rsp", Width'(bus.rsp_valid), Width'(0));

    // Done on the expiry cycle wins over the timeout.
    bus.req_valid = 4'b0001;
    run_txn(Timeout, 1'b0, 1'b1, Width'(5), 0, 1'b1, 1'b0);

    // Reset while waiting on the adder.
    set_req(2, rand_w() % mp, rand_w() % mp);
    bus.req_valid = 4'b0100;
    #1;
    check("rst_grant", Width'(bus.req_ready), Width'(4'b0100));
    repeat (3) @(negedge i_clk);
    bus.req_valid = '0;
    check("rst_busy_before", Width'(bus.busy), Width'(1));
    i_rst_n = 1'b0;
    #1;
    check_quiet("rst_wait");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mptr = 0;
    @(negedge i_clk);
    bus.add_done   = 1'b1;
    bus.add_result = '1;
    @(negedge i_clk);
    bus.add_done = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (bus.rsp_valid || bus.busy) cyc++;
    end
    check("post_rst_quiet", Width'(cyc), Width'(0));
    check_quiet("post_rst");
    set_req(3, rand_w() % mp, rand_w() % mp);
    bus.req_valid = 4'b1000;
    run_txn(2, 1'b0, 1'b0, '0, 1, 1'b1, 1'b0);

    // Randomized traffic: requesters join at random and hold until granted.
    do_reset();
    set_p(rand_w() | {1'b1, {(Width - 1){1'b0}}});
    for (int t = 0; t < 30; t++) begin
      add = NReq'($urandom_range(0, (1 << NReq) - 1));
      for (int i = 0; i < NReq; i++) begin
        if (add[IdW'(i)] && !bus.req_valid[IdW'(i)]) set_req(i, rand_w() % mp, rand_w() % mp);
      end
      bus.req_valid = bus.req_valid | add;
      if (bus.req_valid == '0) begin
        set_req(0, rand_w() % mp, rand_w() % mp);
        bus.req_valid = 4'b0001;
      end
      run_txn($urandom_range(1, Timeout), ($urandom_range(0, 7) == 0), 1'b0, '0,
              $urandom_range(0, 3), 1'b1, 1'b0);
    end
    bus.req_valid = '0;
    @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modadd_arbiter.md
Name: modadd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one modular adder (A+B mod p, start/done handshake, 256-bit) between N_REQ requesters, such as point-add and point-double controllers in the ECC datapath.
- Accepts one request at a time and latches its operands.
- Pulses the adder start, then waits for done, with a watchdog timeout.
- Returns the result tagged with the requester ID over a valid/ready response channel.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 256, operand/modulus width
TIMEOUT, 64, max cycles waited for add_done before error (>=2)
ID_W, $clog2(N_REQ), requester ID width

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept (one-hot or zero)
req_a  input  N_REQ*WIDTH  flattened operand A, slice i = [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  flattened operand B
mod_p  input  WIDTH  modulus, sampled at accept
add_start  output  1  one-cycle start pulse to adder
add_a, add_b, add_p  output  WIDTH each  registered operands to adder
add_result  input  WIDTH  adder result
add_done  input  1  adder done pulse
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  ID_W  requester index of response
rsp_data  output  WIDTH  result (0 on error)
rsp_err  output  1  1 = timeout
busy  output  1  state != IDLE

Behaviour:
- Reset, async: state=IDLE, ptr=0, all outputs 0, add_a/add_b/add_p=0, timer=0. Reset mid-operation aborts the transaction. No response is produced. A later stray add_done is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[g] is combinationally 1 only in IDLE and only for g. All other req_ready bits are 0.
  - When any req_valid is set, the handshake completes that cycle. Latch req_a[g], req_b[g], mod_p and g into rsp_id. Set ptr <= (g+1) mod N_REQ. Next state = ISSUE.
  - With no req_valid, remain in IDLE.
- ISSUE: add_start=1 for exactly this cycle, timer<=0, next state = WAIT.
- WAIT:
  - add_a/add_b/add_p are held stable.
  - On add_done: rsp_data<=add_result, rsp_err<=0, next state = RESP.
  - Else if timer==TIMEOUT-1: rsp_data<=0, rsp_err<=1, next state = RESP.
  - Else timer<=timer+1.
  - If add_done arrives in the same cycle as expiry, add_done wins and there is no error.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, next state = IDLE and rsp_valid drops the next cycle.
  - No new grant is issued in RESP. The earliest next accept is the cycle after the response handshake.
- add_done outside WAIT (including the ISSUE cycle) is ignored.
- Latency: accept at cycle T, add_start at T+1, WAIT from T+2. With add_done at cycle D, rsp_valid is 1 from D+1. Minimum accept-to-response is 3 cycles with an instant adder.
- Throughput: one transaction in flight. A requester must hold req_valid and its operands until req_ready.
- Fairness: after granting i, i becomes lowest priority. A continuously requesting requester waits at most N_REQ-1 transactions.

Test Plan:
1. Single request: reset, then req_valid[1]=1, A=50, B=60, mod_p=97, adder model done 3 cycles after start with result 13. Required: req_ready=0010 for one cycle, add_start single pulse, then rsp_valid with rsp_id=1, rsp_data=13, rsp_err=0.
2. Round-robin: req_valid=1111 held, each with a distinct A. Required: grant order 0,1,2,3,0. Each rsp_id matches its grant and each rsp_data matches its own operands.
3. Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid, with req_valid[2]=1 pending. Required: rsp_valid, rsp_id and rsp_data stable. req_ready stays 0 until the cycle after rsp_ready=1.
4. Timeout: TIMEOUT=8, add_done never asserted. Required: rsp_valid 9 cycles after add_start (8 WAIT cycles plus 1) with rsp_err=1 and rsp_data=0. A late add_done pulse has no effect.
5. Done at expiry: add_done asserted exactly on the timer==TIMEOUT-1 cycle with result 5. Required: rsp_err=0, rsp_data=5.
6. Reset in WAIT: assert i_rst_n=0 mid-WAIT, then release, then pulse add_done. Required: all outputs 0, busy=0, no rsp_valid. A next req_valid[3] alone is granted and completes normally.
